hazard_forward_unit: RTL and testbench

Parametrised successor to the pipeline forwarding/hazard control for the 5-stage RISC-V core (F, D, X, M, W).
- Generates the ALU operand forward selects from the M and W stages.
- Runs a sequential load-use stall FSM that supports a multi-cycle data memory.
- Drives branch flushes.
- Keeps saturating stall and flush performance counters.
- Sits beside the pipeline registers and drives their hold, bubble and flush controls.

---
 rtl/hazard_forward_unit.sv | 192 +++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard control for a 5-stage RISC-V pipeline (F, D, X, M, W).
// Selects ALU operand bypass sources and sequences load-use stalls for a
// data memory with LOAD_LAT extra cycles. Squashes younger stages on taken
// branches and keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, rst               core clock, synchronous active-high reset
//   inst_d/x/m/w           instruction words held in D, X, M, W
//   RegWEn_x/m/w           stage instruction writes its rd
//   br_taken               branch/jump resolved taken in X this cycle
//   F_SelA, F_SelB         rs1/rs2 bypass select (00 regfile, 01 M, 10 W)
//   stall_fd               hold PC and F/D register
//   bubble_x               load NOP into D/X register
//   flush                  squash F/D and D/X registers
//   stall_cnt, flush_cnt   saturating cycle counts of stall_fd / flush
module hazard_forward_unit #(
    parameter int unsigned LOAD_LAT = 0,
    parameter int unsigned CNT_W    = 16,
    parameter logic [6:0]  OPC_LOAD = 7'b0000011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_d,
    input  logic [31:0]      inst_x,
    input  logic [31:0]      inst_m,
    input  logic [31:0]      inst_w,
    input  logic             RegWEn_x,
    input  logic             RegWEn_m,
    input  logic             RegWEn_w,
    input  logic             br_taken,
    output logic [1:0]       F_SelA,
    output logic [1:0]       F_SelB,
    output logic             stall_fd,
    output logic             bubble_x,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned LAT_W = 3;
    // Cycles still to stall after the detecting cycle, minus one.
    localparam logic [LAT_W-1:0] CNT_INIT =
        (LOAD_LAT > 0) ? LAT_W'(LOAD_LAT - 1) : '0;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opc_d, opc_x, opc_m;
    logic [4:0] rs1_d, rs2_d, rd_x, rs1_x, rs2_x, rd_m, rd_w;
    logic       fwd_m_ok, fwd_w_ok, lu_haz;
    logic       unused_bits;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_S) || (opc == OPC_B);
    endfunction

    // Instruction field extraction
    assign opc_d = inst_d[6:0];
    assign rs1_d = inst_d[19:15];
    assign rs2_d = inst_d[24:20];
    assign opc_x = inst_x[6:0];
    assign rd_x  = inst_x[11:7];
    assign rs1_x = inst_x[19:15];
    assign rs2_x = inst_x[24:20];
    assign opc_m = inst_m[6:0];
    assign rd_m  = inst_m[11:7];
    assign rd_w  = inst_w[11:7];

    assign unused_bits = ^{inst_d[31:25], inst_d[14:7], inst_x[31:25], inst_x[14:12],
                           inst_m[31:12], inst_w[31:12], inst_w[6:0]};

    // Operand bypass; a load in M has no data yet so it never forwards from M
    always_comb begin
        fwd_m_ok = RegWEn_m && (rd_m != 5'd0) && (opc_m != OPC_LOAD);
        fwd_w_ok = RegWEn_w && (rd_w != 5'd0);
        F_SelA   = 2'b00;
        F_SelB   = 2'b00;
        if (uses_rs1(opc_x) && fwd_m_ok && (rd_m == rs1_x)) begin
            F_SelA = 2'b01;
        end else if (uses_rs1(opc_x) && fwd_w_ok && (rd_w == rs1_x)) begin
            F_SelA = 2'b10;
        end
        if (uses_rs2(opc_x) && fwd_m_ok && (rd_m == rs2_x)) begin
            F_SelB = 2'b01;
        end else if (uses_rs2(opc_x) && fwd_w_ok && (rd_w == rs2_x)) begin
            F_SelB = 2'b10;
        end
    end

    // Load in X feeding the instruction in D
    always_comb begin
        lu_haz = RegWEn_x && (opc_x == OPC_LOAD) && (rd_x != 5'd0) &&
                 ((uses_rs1(opc_d) && (rs1_d == rd_x)) ||
                  (uses_rs2(opc_d) && (rs2_d == rd_x)));
    end

    // Stall/flush sequencing; strobes are forced low while in reset
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_fd = 1'b0;
        flush    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (br_taken) begin
                        flush   = 1'b1;
                        state_d = S_FLUSH;
                    end else if (lu_haz) begin
                        stall_fd = 1'b1;
                        if (LOAD_LAT > 0) begin
                            state_d = S_STALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                S_STALL: begin
                    if (br_taken) begin
                        flush   = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        stall_fd = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q - LAT_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Give the refetched instruction one clean cycle
                    if (br_taken) begin
                        flush = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        bubble_x = stall_fd;
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fd && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit. Three instances (LOAD_LAT 0,
// 2, 3; the last with 4-bit counters) share stimulus and are compared every
// cycle against a reference model, plus directed scenario checks.
module tb_hazard_forward_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] inst_d, inst_x, inst_m, inst_w;
    logic        we_x, we_m, we_w, br;

    logic [1:0]  fsa0, fsb0, fsa2, fsb2, fsa3, fsb3;
    logic        sfd0, bx0, fl0, sfd2, bx2, fl2, sfd3, bx3, fl3;
    logic [15:0] sc0, fc0, sc2, fc2;
    logic [3:0]  sc3, fc3;

    hazard_forward_unit #(.LOAD_LAT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .inst_d(inst_d), .inst_x(inst_x), .inst_m(inst_m),
        .inst_w(inst_w), .RegWEn_x(we_x), .RegWEn_m(we_m), .RegWEn_w(we_w),
        .br_taken(br), .F_SelA(fsa0), .F_SelB(fsb0), .stall_fd(sfd0),
        .bubble_x(bx0), .flush(fl0), .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_forward_unit #(.LOAD_LAT(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .inst_d(inst_d), .inst_x(inst_x), .inst_m(inst_m),
        .inst_w(inst_w), .RegWEn_x(we_x), .RegWEn_m(we_m), .RegWEn_w(we_w),
        .br_taken(br), .F_SelA(fsa2), .F_SelB(fsb2), .stall_fd(sfd2),
        .bubble_x(bx2), .flush(fl2), .stall_cnt(sc2), .flush_cnt(fc2));

    hazard_forward_unit #(.LOAD_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .inst_d(inst_d), .inst_x(inst_x), .inst_m(inst_m),
        .inst_w(inst_w), .RegWEn_x(we_x), .RegWEn_m(we_m), .RegWEn_w(we_w),
        .br_taken(br), .F_SelA(fsa3), .F_SelB(fsb3), .stall_fd(sfd3),
        .bubble_x(bx3), .flush(fl3), .stall_cnt(sc3), .flush_cnt(fc3));

    int n_cmp;
    int n_fail;

    // Reference model: stall cycles still owed, post-branch clean cycle, counts
    int lat  [3] = '{0, 2, 3};
    int cmax [3] = '{65535, 65535, 15};
    int m_left [3];
    bit m_fl   [3];
    int m_sc   [3];
    int m_fc   [3];

    function automatic logic [31:0] mk(logic [6:0] opc, int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), opc};
    endfunction

    function automatic bit reads_rs1(logic [31:0] i);
        return !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic bit reads_rs2(logic [31:0] i);
        return i[6:0] inside {OP_R, OP_S, OP_B};
    endfunction

    function automatic logic [1:0] exp_fwd(bit first);
        int  src;
        bit  rd_used;
        src     = first ? int'(inst_x[19:15]) : int'(inst_x[24:20]);
        rd_used = first ? reads_rs1(inst_x) : reads_rs2(inst_x);
        if (rd_used && we_m && inst_m[11:7] != 0 && int'(inst_m[11:7]) == src &&
            inst_m[6:0] != OP_LOAD)
            return 2'b01;
        if (rd_used && we_w && inst_w[11:7] != 0 && int'(inst_w[11:7]) == src)
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit exp_haz();
        bit dep;
        dep = (reads_rs1(inst_d) && inst_d[19:15] == inst_x[11:7]) ||
              (reads_rs2(inst_d) && inst_d[24:20] == inst_x[11:7]);
        return we_x && inst_x[6:0] == OP_LOAD && inst_x[11:7] != 0 && dep;
    endfunction

    task automatic exp_ctl(int k, output bit es, output bit ef);
        es = 1'b0;
        ef = 1'b0;
        if (!rst) begin
            if (br) ef = 1'b1;
            else if (!m_fl[k] && (m_left[k] > 0 || exp_haz())) es = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_fl[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_check();
        logic [1:0]  ea, eb, oa, ob;
        logic        os, obx, ofl;
        logic [31:0] osc, ofc;
        bit          es, ef;
        ea = exp_fwd(1'b1);
        eb = exp_fwd(1'b0);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin oa = fsa0; ob = fsb0; os = sfd0; obx = bx0; ofl = fl0;
                         osc = 32'(sc0); ofc = 32'(fc0); end
                1: begin oa = fsa2; ob = fsb2; os = sfd2; obx = bx2; ofl = fl2;
                         osc = 32'(sc2); ofc = 32'(fc2); end
                default: begin oa = fsa3; ob = fsb3; os = sfd3; obx = bx3; ofl = fl3;
                         osc = 32'(sc3); ofc = 32'(fc3); end
            endcase
            exp_ctl(k, es, ef);
            chk($sformatf("u%0d.F_SelA", k), 32'(oa), 32'(ea));
            chk($sformatf("u%0d.F_SelB", k), 32'(ob), 32'(eb));
            chk($sformatf("u%0d.stall_fd", k), 32'(os), 32'(es));
            chk($sformatf("u%0d.bubble_x", k), 32'(obx), 32'(es));
            chk($sformatf("u%0d.flush", k), 32'(ofl), 32'(ef));
            chk($sformatf("u%0d.stall_cnt", k), osc, 32'(m_sc[k]));
            chk($sformatf("u%0d.flush_cnt", k), ofc, 32'(m_fc[k]));
        end
    endtask

    task automatic model_next();
        bit es, ef;
        for (int k = 0; k < 3; k++) begin
            exp_ctl(k, es, ef);
            if (rst) begin
                m_left[k] = 0; m_fl[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                if (es && m_sc[k] < cmax[k]) m_sc[k]++;
                if (ef && m_fc[k] < cmax[k]) m_fc[k]++;
                if (br) begin
                    m_fl[k] = 1'b1; m_left[k] = 0;
                end else if (m_fl[k]) begin
                    m_fl[k] = 1'b0;
                end else if (m_left[k] > 0) begin
                    m_left[k]--;
                end else if (exp_haz()) begin
                    m_left[k] = lat[k];
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic nop_all();
        inst_d = NOP; inst_x = NOP; inst_m = NOP; inst_w = NOP;
        we_x = 1'b0; we_m = 1'b0; we_w = 1'b0; br = 1'b0;
    endtask

    task automatic load_use();
        nop_all();
        inst_x = mk(OP_LOAD, 5, 1, 0);  // lw  x5,0(x1)
        inst_d = mk(OP_R, 6, 5, 2);     // add x6,x5,x2
        we_x   = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [9];
        n_cmp  = 0;
        n_fail = 0;
        ops = '{OP_LOAD, OP_I, OP_R, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

        // Reset with a live hazard on the inputs: strobes must stay low
        rst = 1'b1;
        load_use();
        @(posedge clk);
        #1;
        model_reset();
        settle();
        chk("reset.stall_fd", 32'(sfd2), 0);
        chk("reset.stall_cnt", 32'(sc0), 0);
        tick();
        rst = 1'b0;
        nop_all();
        cycle();

        // Load-use pair: 1 stall cycle at LOAD_LAT=0, 3 at 2, 4 at 3
        load_use();
        settle();
        chk("lu.stall0_c1", 32'(sfd0), 1);
        chk("lu.bubble0_c1", 32'(bx0), 1);
        chk("lu.stall2_c1", 32'(sfd2), 1);
        tick();
        nop_all();
        inst_d = mk(OP_R, 6, 5, 2);
        inst_m = mk(OP_LOAD, 5, 1, 0);
        we_m   = 1'b1;
        settle();
        chk("lu.stall0_c2", 32'(sfd0), 0);
        chk("lu.stall2_c2", 32'(sfd2), 1);
        tick();
        nop_all();
        inst_x = mk(OP_R, 6, 5, 2);
        inst_w = mk(OP_LOAD, 5, 1, 0);
        we_w   = 1'b1;
        settle();
        chk("lu.fwdA_from_W", 32'(fsa0), 32'h2);
        chk("lu.fwdB_none", 32'(fsb0), 0);
        chk("lu.stall2_c3", 32'(sfd2), 1);
        tick();
        nop_all();
        settle();
        chk("lu.stall2_c4", 32'(sfd2), 0);
        chk("lu.stall3_c4", 32'(sfd3), 1);
        chk("lu.stall_cnt0", 32'(sc0), 1);
        chk("lu.stall_cnt2", 32'(sc2), 3);
        tick();
        settle();
        chk("lu.stall3_c5", 32'(sfd3), 0);
        chk("lu.stall_cnt3", 32'(sc3), 4);
        tick();

        // Reset in the second stall cycle of LOAD_LAT=3 aborts the stall
        load_use();
        settle();
        chk("rst_mid.stall_c1", 32'(sfd3), 1);
        tick();
        rst = 1'b1;
        settle();
        chk("rst_mid.stall_in_rst", 32'(sfd3), 0);
        tick();
        rst = 1'b0;
        nop_all();
        settle();
        chk("rst_mid.stall_after", 32'(sfd3), 0);
        chk("rst_mid.stall_cnt3", 32'(sc3), 0);
        chk("rst_mid.stall_cnt2", 32'(sc2), 0);
        tick();

        // Forwarding priority, x0 and non-reading consumers
        nop_all();
        inst_x = mk(OP_R, 8, 7, 7);
        inst_m = mk(OP_I, 7, 1, 0); we_m = 1'b1;
        inst_w = mk(OP_I, 7, 2, 0); we_w = 1'b1;
        settle();
        chk("fwd.M_priority_A", 32'(fsa0), 32'h1);
        chk("fwd.M_priority_B", 32'(fsb0), 32'h1);
        tick();
        we_m = 1'b0;
        settle();
        chk("fwd.W_only_A", 32'(fsa0), 32'h2);
        tick();
        we_m = 1'b1;
        inst_m = mk(OP_LOAD, 7, 1, 0);
        settle();
        chk("fwd.load_in_M_A", 32'(fsa0), 32'h2);
        tick();
        inst_x = mk(OP_R, 8, 0, 0);
        inst_m = mk(OP_I, 0, 1, 0);
        inst_w = mk(OP_I, 0, 2, 0);
        settle();
        chk("fwd.x0_A", 32'(fsa0), 0);
        tick();
        inst_x = mk(OP_LUI, 8, 7, 7);
        inst_m = mk(OP_I, 7, 1, 0);
        inst_w = mk(OP_I, 7, 2, 0);
        settle();
        chk("fwd.lui_A", 32'(fsa0), 0);
        chk("fwd.lui_B", 32'(fsb0), 0);
        tick();
        inst_x = mk(OP_I, 8, 7, 7);
        settle();
        chk("fwd.addi_A", 32'(fsa0), 32'h1);
        chk("fwd.addi_B", 32'(fsb0), 0);
        tick();

        // Branch beats load-use; branch in FLUSH re-flushes
        load_use();
        br = 1'b1;
        settle();
        chk("br.flush", 32'(fl0), 1);
        chk("br.stall", 32'(sfd0), 0);
        chk("br.bubble", 32'(bx2), 0);
        tick();
        nop_all();
        settle();
        chk("br.after_flush", 32'(fl0), 0);
        chk("br.after_stall", 32'(sfd0), 0);
        chk("br.flush_cnt", 32'(fc0), 1);
        tick();
        br = 1'b1;
        cycle();
        settle();
        chk("br.reflush", 32'(fl2), 1);
        tick();
        nop_all();
        cycle();

        // Held hazard saturates the 4-bit stall counter
        load_use();
        for (int i = 0; i < 20; i++) cycle();
        nop_all();
        settle();
        chk("sat.stall_cnt3", 32'(sc3), 32'hF);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            inst_d = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
            inst_x = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
            inst_m = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
            inst_w = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
            we_x = 1'($urandom);
            we_m = 1'($urandom);
            we_w = 1'($urandom);
            br   = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
